spio_spinnaker_link_tx_arbiter: RTL and testbench
=================================================

// Module: spio_spinnaker_link_tx_arbiter
// PURPOSE
//  Packet-granular round-robin arbiter that shares one spio_spinnaker_link_sender
//  among NUM_IN synchronous 72-bit packet sources. Sits directly in front of the
//  sender's PKT_DATA_IN/PKT_VLD_IN/PKT_RDY_OUT. One registered output stage.
//  Per-input enable mask and a saturating forwarded-packet counter for control/status.
// PARAMETERS
//  NUM_IN    4   number of requesting packet sources (2..8)
//  CNT_BITS  16  width of forwarded-packet counter PKT_CNT_OUT
//  SEL_BITS  2   width of LAST_GNT_OUT; must equal clog2(NUM_IN), minimum 1
// PORTS
//  CLK_IN        in   1            single clock; all logic on posedge
//  RESET_IN      in   1            synchronous, active-low reset
//  EN_IN         in   NUM_IN       per-input enable; 0 = input never granted
//  PKT_DATA_IN   in   72*NUM_IN    input i packet at [72*i +: 72] ({pld,key,hdr})
//  PKT_VLD_IN    in   NUM_IN       input i has a packet
//  PKT_RDY_OUT   out  NUM_IN       input i packet accepted this cycle (vld&rdy)
//  PKT_DATA_OUT  out  72           registered packet to sender
//  PKT_VLD_OUT   out  1            registered valid to sender
//  PKT_RDY_IN    in   1            sender ready
//  LAST_GNT_OUT  out  SEL_BITS     index of most recently granted input
//  CNT_CLR_IN    in   1            synchronous clear of PKT_CNT_OUT
//  PKT_CNT_OUT   out  CNT_BITS     packets accepted from inputs, saturating
// BEHAVIOUR
//  - Reset (RESET_IN==0 at posedge): PKT_VLD_OUT=0, PKT_DATA_OUT=0, LAST_GNT_OUT=NUM_IN-1,
//    PKT_CNT_OUT=0; PKT_RDY_OUT is forced to 0 while RESET_IN==0. Reset mid-transfer
//    discards the held packet; no input handshake completes in a reset cycle.
//  - load = !PKT_VLD_OUT || PKT_RDY_IN (output register empty or draining this cycle).
//  - req[i] = PKT_VLD_IN[i] & EN_IN[i]. Grant = first req index scanning
//    LAST_GNT_OUT+1, +2, ... modulo NUM_IN (wrap NUM_IN-1 -> 0).
//  - PKT_RDY_OUT[i] = load & (grant==i) & |req; combinational, one-hot or zero.
//    PKT_RDY_OUT may depend on PKT_VLD_IN; sources must not make VLD depend on RDY.
//  - On load & |req: PKT_DATA_OUT<=PKT_DATA_IN[grant], PKT_VLD_OUT<=1, LAST_GNT_OUT<=grant.
//  - On load & !|req: PKT_VLD_OUT<=0, data and LAST_GNT_OUT unchanged.
//  - !load (VLD_OUT=1, RDY_IN=0): output held stable; all PKT_RDY_OUT=0.
//  - Latency: input accept cycle N -> PKT_VLD_OUT high from cycle N+1. Throughput
//    1 pkt/clk when PKT_RDY_IN held high. No bubble on back-to-back grants.
//  - Fairness: a continuously requesting enabled input waits at most NUM_IN-1 grants.
//  - EN_IN change takes effect the same cycle; does not affect packet already in
//    output register. Deasserting VLD without acceptance is permitted (no grant stored).
//  - Counter: +1 per accepted input packet; holds at 2^CNT_BITS-1. CNT_CLR_IN has
//    priority: counter<=0 even if a packet is accepted the same cycle.
//  - No packet is dropped, duplicated or reordered per input; data passes bit-exact.
// TESTING
//  1 Reset: hold RESET_IN=0 5 clk with all VLD=1 -> RDY_OUT=0, VLD_OUT=0,
//    LAST_GNT_OUT=3, CNT=0.
//  2 All 4 inputs VLD, RDY_IN=1 -> grants 0,1,2,3,0,... one per clk; key order
//    out matches; CNT=8 after 8 clk.
//  3 Only input 2 VLD, RDY_IN=1 -> 1 pkt/clk from input 2; LAST_GNT_OUT=2 steady.
//  4 RDY_IN=0 for 10 clk with VLD_OUT=1 -> PKT_DATA_OUT stable, all RDY_OUT=0;
//    release -> next grant follows LAST_GNT_OUT+1.
//  5 EN_IN=4'b1010, all VLD -> only inputs 1,3 alternate; inputs 0,2 never RDY.
//  6 CNT_BITS=4, 20 accepts -> CNT saturates at 15; CNT_CLR_IN pulse with accept -> 0.
//  7 RESET_IN=0 while VLD_OUT=1, RDY_IN=0 -> next clk VLD_OUT=0, packet lost, CNT=0.

Source files
------------

// File: rtl/spio_spinnaker_link_tx_arbiter.sv
// Packet-granular round-robin arbiter feeding one SpiNNaker link sender.
// One registered output stage, per-input enable mask, saturating packet counter.
module spio_spinnaker_link_tx_arbiter #(
  parameter int NUM_IN   = 4,
  parameter int CNT_BITS = 16,
  parameter int SEL_BITS = 2
) (
  input  logic                   CLK_IN,
  input  logic                   RESET_IN,
  input  logic [NUM_IN-1:0]      EN_IN,
  input  logic [72*NUM_IN-1:0]   PKT_DATA_IN,
  input  logic [NUM_IN-1:0]      PKT_VLD_IN,
  output logic [NUM_IN-1:0]      PKT_RDY_OUT,
  output logic [71:0]            PKT_DATA_OUT,
  output logic                   PKT_VLD_OUT,
  input  logic                   PKT_RDY_IN,
  output logic [SEL_BITS-1:0]    LAST_GNT_OUT,
  input  logic                   CNT_CLR_IN,
  output logic [CNT_BITS-1:0]    PKT_CNT_OUT
);

  logic                r_vld;
  logic [71:0]         r_data;
  logic [SEL_BITS-1:0] r_last;
  logic [CNT_BITS-1:0] r_cnt;

  logic [NUM_IN-1:0]   w_req;
  logic                w_any;
  logic                w_load;
  logic                w_accept;
  logic                w_found_hi;
  logic [SEL_BITS-1:0] w_grant;
  logic [71:0]         w_gnt_data;

  assign w_req    = PKT_VLD_IN & EN_IN;
  assign w_any    = |w_req;
  assign w_load   = !r_vld || PKT_RDY_IN;
  assign w_accept = RESET_IN && w_load && w_any;

  // Round-robin: lowest requester above the last grant, else lowest overall (wrap).
  always_comb begin
    w_grant    = r_last;
    w_found_hi = 1'b0;
    for (int i = NUM_IN - 1; i >= 0; i--) begin
      if (w_req[i] && (i > int'(r_last))) begin
        w_grant    = SEL_BITS'(i);
        w_found_hi = 1'b1;
      end
    end
    if (!w_found_hi) begin
      for (int i = NUM_IN - 1; i >= 0; i--) begin
        if (w_req[i]) w_grant = SEL_BITS'(i);
      end
    end
  end

  always_comb begin
    w_gnt_data = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (SEL_BITS'(i) == w_grant) w_gnt_data = PKT_DATA_IN[72*i +: 72];
    end
  end

  always_comb begin
    PKT_RDY_OUT = '0;
    if (w_accept) PKT_RDY_OUT[w_grant] = 1'b1;
  end

  always_ff @(posedge CLK_IN) begin
    if (!RESET_IN) begin
      r_vld  <= 1'b0;
      r_data <= '0;
      r_last <= SEL_BITS'(NUM_IN - 1);
      r_cnt  <= '0;
    end else begin
      if (w_load) begin
        r_vld <= w_any;
        if (w_any) begin
          r_data <= w_gnt_data;
          r_last <= w_grant;
        end
      end
      // Clear wins over a same-cycle accept.
      if (CNT_CLR_IN)
        r_cnt <= '0;
      else if (w_accept && (r_cnt != {CNT_BITS{1'b1}}))
        r_cnt <= r_cnt + CNT_BITS'(1);
    end
  end

  assign PKT_DATA_OUT = r_data;
  assign PKT_VLD_OUT  = r_vld;
  assign LAST_GNT_OUT = r_last;
  assign PKT_CNT_OUT  = r_cnt;

endmodule

// File: tb/tb_spio_spinnaker_link_tx_arbiter.sv
// Scoreboard bench for the link tx arbiter: reference model predicts grants and
// packets, a separate monitor checks each packet taken by the sender.
module tb_spio_spinnaker_link_tx_arbiter;
  localparam int N  = 4;
  localparam int CB = 4;
  localparam int CNT_MAX = (1 << CB) - 1;

  logic            CLK_IN = 1'b0;
  logic            RESET_IN;
  logic [N-1:0]    EN_IN;
  logic [72*N-1:0] PKT_DATA_IN;
  logic [N-1:0]    PKT_VLD_IN;
  logic [N-1:0]    PKT_RDY_OUT;
  logic [71:0]     PKT_DATA_OUT;
  logic            PKT_VLD_OUT;
  logic            PKT_RDY_IN;
  logic [1:0]      LAST_GNT_OUT;
  logic            CNT_CLR_IN;
  logic [CB-1:0]   PKT_CNT_OUT;

  always #5 CLK_IN = ~CLK_IN;

  spio_spinnaker_link_tx_arbiter #(.NUM_IN(N), .CNT_BITS(CB), .SEL_BITS(2)) dut (
    .CLK_IN(CLK_IN), .RESET_IN(RESET_IN), .EN_IN(EN_IN), .PKT_DATA_IN(PKT_DATA_IN),
    .PKT_VLD_IN(PKT_VLD_IN), .PKT_RDY_OUT(PKT_RDY_OUT), .PKT_DATA_OUT(PKT_DATA_OUT),
    .PKT_VLD_OUT(PKT_VLD_OUT), .PKT_RDY_IN(PKT_RDY_IN), .LAST_GNT_OUT(LAST_GNT_OUT),
    .CNT_CLR_IN(CNT_CLR_IN), .PKT_CNT_OUT(PKT_CNT_OUT)
  );

  typedef struct {
    logic [71:0] data;
    int          src;
  } exp_t;

  exp_t        q[$];
  int          checks   = 0;
  int          failures = 0;
  logic [71:0] pkt [N];

  logic         n_rst, n_rdy, n_clr;
  logic [N-1:0] n_en, n_vld;

  logic         m_vld;
  int           m_last;
  int           m_cnt;
  logic [N-1:0] acc_prev;

  function automatic logic [71:0] new_pkt();
    return {$urandom, $urandom, 8'($urandom)};
  endfunction

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus: apply staged inputs, check state, predict this edge.
  task automatic step();
    logic [N-1:0] req;
    logic [N-1:0] exp_rdy;
    logic         load;
    int           g;
    int           idx;
    @(negedge CLK_IN);
    #1;
    for (int i = 0; i < N; i++) begin
      if (acc_prev[i]) pkt[i] = new_pkt();
      PKT_DATA_IN[72*i +: 72] = pkt[i];
    end
    RESET_IN   = n_rst;
    EN_IN      = n_en;
    PKT_VLD_IN = n_vld;
    PKT_RDY_IN = n_rdy;
    CNT_CLR_IN = n_clr;
    #1;
    check("vld_out",  72'(PKT_VLD_OUT),  72'(m_vld));
    check("last_gnt", 72'(LAST_GNT_OUT), 72'(m_last));
    check("pkt_cnt",  72'(PKT_CNT_OUT),  72'(m_cnt));
    acc_prev = '0;
    exp_rdy  = '0;
    if (!n_rst) begin
      check("rdy_out_in_reset", 72'(PKT_RDY_OUT), 72'(0));
      m_vld  = 1'b0;
      m_last = N - 1;
      m_cnt  = 0;
      q.delete();
    end else begin
      req  = n_vld & n_en;
      load = !m_vld || n_rdy;
      if (load && (req != 0)) begin
        g = -1;
        for (int k = 1; k <= N; k++) begin
          idx = (m_last + k) % N;
          if (g < 0 && req[idx]) g = idx;
        end
        exp_rdy[g] = 1'b1;
        q.push_back('{data: pkt[g], src: g});
        m_last   = g;
        m_vld    = 1'b1;
        acc_prev = exp_rdy;
      end else if (load) begin
        m_vld = 1'b0;
      end
      check("rdy_out", 72'(PKT_RDY_OUT), 72'(exp_rdy));
      if (n_clr) m_cnt = 0;
      else if (acc_prev != 0 && m_cnt < CNT_MAX) m_cnt++;
    end
  endtask

  task automatic run(input int cycles);
    for (int c = 0; c < cycles; c++) step();
  endtask

  // Monitor: a packet leaves whenever the sender sees valid&ready at the coming edge.
  always begin
    exp_t e;
    @(negedge CLK_IN);
    #3;
    if (RESET_IN === 1'b1 && PKT_VLD_OUT === 1'b1 && PKT_RDY_IN === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_packet actual=%h expected=none", PKT_DATA_OUT);
      end else begin
        e = q.pop_front();
        check("pkt_data", PKT_DATA_OUT, e.data);
        check("pkt_src",  72'(LAST_GNT_OUT), 72'(e.src));
      end
    end
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      pkt[i] = new_pkt();
      PKT_DATA_IN[72*i +: 72] = pkt[i];
    end
    RESET_IN = 1'b0; EN_IN = '1; PKT_VLD_IN = '1; PKT_RDY_IN = 1'b1; CNT_CLR_IN = 1'b0;
    m_vld = 1'b0; m_last = N - 1; m_cnt = 0; acc_prev = '0;

    // Reset held with all inputs requesting.
    n_rst = 1'b0; n_en = '1; n_vld = '1; n_rdy = 1'b1; n_clr = 1'b0;
    run(5);

    // All inputs requesting, sender always ready.
    n_rst = 1'b1;
    run(8);

    // Single requester.
    n_vld = 4'b0100;
    run(5);

    // Sender stalls with a packet held, then releases.
    n_vld = '1; n_rdy = 1'b0;
    run(10);
    n_rdy = 1'b1;
    run(4);

    // Enable mask restricts to inputs 1 and 3.
    n_en = 4'b1010;
    run(8);

    // Counter saturation, then clear coinciding with an accept.
    n_en = '1; n_rst = 1'b0;
    run(1);
    n_rst = 1'b1;
    run(20);
    n_clr = 1'b1;
    run(1);
    n_clr = 1'b0;
    run(3);

    // Reset while a packet is held by a stalled sender.
    n_rdy = 1'b0;
    run(2);
    n_rst = 1'b0;
    run(1);
    n_rst = 1'b1; n_vld = '0;
    run(2);

    // Randomized traffic.
    for (int c = 0; c < 1500; c++) begin
      n_rst = ($urandom_range(99) != 0);
      n_en  = ($urandom_range(4) != 0) ? 4'hF : 4'($urandom);
      n_vld = 4'($urandom);
      n_rdy = ($urandom_range(9) < 7);
      n_clr = ($urandom_range(49) == 0);
      step();
    end

    // Drain.
    n_rst = 1'b1; n_vld = '0; n_rdy = 1'b1; n_clr = 1'b0;
    run(4);
    #5;
    check("queue_drained", 72'(q.size()), 72'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
